// File: rtl/datapath_pkg.sv
// Shared encodings for the sequenced datapath:
// ALU ops, shift kinds, sequencer states and status bit positions.
package datapath_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_NOT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_e;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_V = 2;

endpackage

// File: rtl/alu_shift_unit.sv
// Combinational shifter, operand select, ALU and flag generation.
// Shift applies only to the register B operand, never to the immediate.
module alu_shift_unit
  import datapath_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  input  alu_op_e           aluop,
  input  shift_e            shift,
  input  logic              use_imm,
  input  logic              zero_a,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        flags
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] w_sh;
  logic [DATA_W-1:0] w_ain;
  logic [DATA_W-1:0] w_bin;
  logic              w_v;

  always_comb begin
    w_sh = b;
    unique case (shift)
      SH_NONE: w_sh = b;
      SH_LSL1: w_sh = {b[MSB-1:0], 1'b0};
      SH_LSR1: w_sh = {1'b0, b[MSB:1]};
      SH_ASR1: w_sh = {b[MSB], b[MSB:1]};
      default: w_sh = b;
    endcase
  end

  assign w_ain = zero_a ? '0 : a;
  assign w_bin = use_imm ? imm : w_sh;

  always_comb begin
    result = '0;
    w_v    = 1'b0;
    unique case (aluop)
      OP_ADD: begin
        result = w_ain + w_bin;
        w_v = (w_ain[MSB] == w_bin[MSB])
            & (result[MSB] != w_ain[MSB]);
      end
      OP_SUB: begin
        result = w_ain - w_bin;
        w_v = (w_ain[MSB] != w_bin[MSB])
            & (result[MSB] != w_ain[MSB]);
      end
      OP_AND: result = w_ain & w_bin;
      OP_NOT: result = ~w_bin;
      default: result = '0;
    endcase
  end

  always_comb begin
    flags       = '0;
    flags[ST_Z] = (result == '0);
    flags[ST_N] = result[MSB];
    flags[ST_V] = w_v;
  end

endmodule

// File: rtl/seq_datapath.sv
// Register file plus a five-state sequencer that runs one ALU or
// MOVI instruction per accepted command through the A/B/C registers.
module seq_datapath
  import datapath_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS = 8,
  localparam int RN_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_movi,
  input  logic [1:0]        cmd_aluop,
  input  logic [1:0]        cmd_shift,
  input  logic [RN_W-1:0]   cmd_rn,
  input  logic [RN_W-1:0]   cmd_rm,
  input  logic [RN_W-1:0]   cmd_rd,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic              cmd_use_imm,
  input  logic              cmd_zero_a,
  input  logic              cmd_wb,
  input  logic              cmd_setflags,
  output logic              done,
  output logic [DATA_W-1:0] datapath_out,
  output logic [2:0]        status,
  input  logic [RN_W-1:0]   dbg_rnum,
  output logic [DATA_W-1:0] dbg_rdata
);

  state_e r_state;
  state_e w_next;

  logic              r_movi;
  alu_op_e           r_op;
  shift_e            r_sh;
  logic [RN_W-1:0]   r_rn;
  logic [RN_W-1:0]   r_rm;
  logic [RN_W-1:0]   r_rd;
  logic [DATA_W-1:0] r_imm;
  logic              r_use_imm;
  logic              r_zero_a;
  logic              r_wb;
  logic              r_sf;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_c;
  logic [2:0]        r_status;
  logic              r_done;

  logic [DATA_W-1:0] w_res;
  logic [2:0]        w_flags;

  alu_shift_unit #(.DATA_W(DATA_W)) u_alu (
    .a       (r_a),
    .b       (r_b),
    .imm     (r_imm),
    .aluop   (r_op),
    .shift   (r_sh),
    .use_imm (r_use_imm),
    .zero_a  (r_zero_a),
    .result  (w_res),
    .flags   (w_flags)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (cmd_valid) w_next = S_LDA;
      S_LDA:   w_next = r_movi ? S_IDLE : S_LDB;
      S_LDB:   w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_movi    <= 1'b0;
      r_op      <= OP_ADD;
      r_sh      <= SH_NONE;
      r_rn      <= '0;
      r_rm      <= '0;
      r_rd      <= '0;
      r_imm     <= '0;
      r_use_imm <= 1'b0;
      r_zero_a  <= 1'b0;
      r_wb      <= 1'b0;
      r_sf      <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_status  <= '0;
      r_done    <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      unique case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_movi    <= cmd_movi;
          r_op      <= alu_op_e'(cmd_aluop);
          r_sh      <= shift_e'(cmd_shift);
          r_rn      <= cmd_rn;
          r_rm      <= cmd_rm;
          r_rd      <= cmd_rd;
          r_imm     <= cmd_imm;
          r_use_imm <= cmd_use_imm;
          r_zero_a  <= cmd_zero_a;
          r_wb      <= cmd_wb;
          r_sf      <= cmd_setflags;
        end
        S_LDA: if (r_movi) begin
          r_regs[r_rd] <= r_imm;
          r_c          <= r_imm;
          r_done       <= 1'b1;
        end else begin
          r_a <= r_regs[r_rn];
        end
        S_LDB: r_b <= r_regs[r_rm];
        S_EXEC: begin
          r_c <= w_res;
          if (r_sf) r_status <= w_flags;
        end
        S_WB: begin
          if (r_wb) r_regs[r_rd] <= r_c;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready    = (r_state == S_IDLE);
  assign done         = r_done;
  assign datapath_out = r_c;
  assign status       = r_status;
  assign dbg_rdata    = r_regs[dbg_rnum];

endmodule
